dmem_ctrl: RTL and testbench

Data-memory access controller between the single-cycle core's memory stage (ALU_result address, Read_data_2 store data, MemRead/MemWrite) and a multi-cycle backing data memory with a req/ack handshake. Converts each core load/store into one handshake transaction. Stalls the core (PC and register-file write held) until the transaction completes. Returns load data to the MemtoReg write-back mux.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/dmem_ctrl_if.sv | 22 ++
 rtl/sat_counter.sv | 24 ++
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// the bus-error read pattern and the default backing-memory address width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] DEADBEEF       = 32'hDEAD_BEEF;
  localparam int          DEFAULT_ADDR_W = 10;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/acknowledge bus between the access controller (master) and the
// multi-cycle backing data memory (slave).
interface dmem_ctrl_if #(
  parameter int ADDR_W = mips_mem_pkg::DEFAULT_ADDR_W
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sat_counter.sv
// 32-bit incrementer that sticks at all-ones; clr has priority over inc.
module sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Turns each core load/store into one req/ack transaction and stalls the core
// until it completes. Build with DMEM_TIMEOUT_EN for the REQ watchdog and Bus_err.
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Stall,
  output logic        Align_err,
  dmem_ctrl_if.master mem,
  output logic [31:0] Stall_cycles
`ifdef DMEM_TIMEOUT_EN
  ,
  output logic        Bus_err
`endif
);

  mem_state_e        state_reg, state_next;
  logic              access, aligned;
  logic              start, complete, timed_out;
  logic [31:0]       read_data_reg;
  logic              align_err_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  // Address bits above the backing-memory word range are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[31:ADDR_W+2];

  assign access  = MemRead | MemWrite;
  assign aligned = (Address[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  logic [31:0] to_count;
  logic        bus_err_reg;

  sat_counter u_timeout_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (state_reg != REQ),
    .inc   (state_reg == REQ),
    .count (to_count)
  );
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    Stall      = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access && aligned) begin
          Stall      = 1'b1;
          start      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (mem.mem_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (to_count == 32'(TIMEOUT - 1)) begin
          complete   = 1'b1;
          timed_out  = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      read_data_reg <= '0;
      align_err_reg <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      align_err_reg <= (state_reg == IDLE) && access && !aligned;
      if (start) begin
        addr_reg  <= Address[ADDR_W+1:2];
        wdata_reg <= Write_data;
        we_reg    <= MemWrite;
      end
      if (complete && !we_reg) begin
        read_data_reg <= timed_out ? DEADBEEF : mem.mem_rdata;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus_err_reg <= 1'b0;
    end else if (timed_out) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign Bus_err = bus_err_reg;
`endif

  sat_counter u_stall_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (1'b0),
    .inc   (Stall),
    .count (Stall_cycles)
  );

  // mem_req follows the state so an async reset drops it without waiting for a clock.
  assign mem.mem_req   = (state_reg == REQ);
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign Read_data     = read_data_reg;
  assign Align_err     = align_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected memory transactions are queued when
// the core-side access is driven and checked when mem_req appears.
module tb_dmem_ctrl;
  import mips_mem_pkg::*;

  localparam int AW = 10;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Stall;
  logic        Align_err;
  logic [31:0] Stall_cycles;
`ifdef DMEM_TIMEOUT_EN
  logic        Bus_err;
`endif

  dmem_ctrl_if #(.ADDR_W(AW)) mem_bus ();

  always #5 CLK = ~CLK;

  dmem_ctrl #(
    .ADDR_W  (AW)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT (TO)
`endif
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Address      (Address),
    .Write_data   (Write_data),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Read_data    (Read_data),
    .Stall        (Stall),
    .Align_err    (Align_err),
    .mem          (mem_bus),
    .Stall_cycles (Stall_cycles)
`ifdef DMEM_TIMEOUT_EN
    ,
    .Bus_err      (Bus_err)
`endif
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } txn_t;

  txn_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rd_model = '0;
  logic [31:0] stall_model = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One core access; the memory model acks after 'waits' extra REQ cycles.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wd,
                           input logic rd, input logic wr, input int waits,
                           input logic [31:0] rdata);
    txn_t        t, g;
    int          stall_seen;
    logic [31:0] exp_rd;
    t.we    = wr;
    t.addr  = AW'((addr >> 2) & 32'h3FF);
    t.wdata = wd;
    exp_q.push_back(t);
    exp_rd  = wr ? rd_model : rdata;

    Address    = addr;
    Write_data = wd;
    MemRead    = rd;
    MemWrite   = wr;
    #1;
    check_eq("stall_idle", 32'(Stall), 32'd1);
    stall_seen = 1;
    step();

    check_eq("mem_req", 32'(mem_bus.mem_req), 32'd1);
    g = exp_q.pop_front();
    check_eq("mem_we", 32'(mem_bus.mem_we), 32'(g.we));
    check_eq("mem_addr", 32'(mem_bus.mem_addr), 32'(g.addr));
    if (g.we) check_eq("mem_wdata", mem_bus.mem_wdata, g.wdata);

    for (int k = 0; k <= waits; k++) begin
      if (k == waits) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rdata;
      end
      if (Stall) stall_seen++;
      step();
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0BAD_0BAD;
    end

    stall_model = stall_model + 32'(waits + 2);
    rd_model    = exp_rd;
    check_eq("done_stall", 32'(Stall), 32'd0);
    check_eq("done_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("read_data", Read_data, rd_model);
    check_eq("stall_len", 32'(stall_seen), 32'(waits + 2));
    check_eq("stall_cycles", Stall_cycles, stall_model);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    step();
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_read_data", Read_data, 32'd0);
    check_eq("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst_stall_cycles", Stall_cycles, 32'd0);
    check_eq("rst_align_err", 32'(Align_err), 32'd0);
    RESET = 1'b1;
    step();

    do_access(32'h0000_0010, 32'h0,         1'b1, 1'b0, 0, 32'h1234_5678);
    do_access(32'h0000_0020, 32'hCAFE_F00D, 1'b0, 1'b1, 2, 32'h1111_1111);
    do_access(32'h0000_0008, 32'h0000_55AA, 1'b1, 1'b1, 1, 32'hFFFF_FFFF);
    do_access(32'hABCD_E7FC, 32'h0,         1'b1, 1'b0, 0, 32'hA5A5_0001);

    // Misaligned load: no transaction, one-cycle error pulse.
    Address = 32'h0000_0013;
    MemRead = 1'b1;
    #1;
    check_eq("mis_stall", 32'(Stall), 32'd0);
    step();
    check_eq("mis_align_err", 32'(Align_err), 32'd1);
    check_eq("mis_mem_req", 32'(mem_bus.mem_req), 32'd0);
    MemRead = 1'b0;
    step();
    check_eq("mis_align_clr", 32'(Align_err), 32'd0);
    check_eq("mis_read_data", Read_data, rd_model);
    check_eq("mis_stall_cycles", Stall_cycles, stall_model);

    // Stray ack while idle must be ignored.
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h0000_0077;
    step();
    mem_bus.mem_ack = 1'b0;
    check_eq("idle_ack_read_data", Read_data, rd_model);
    check_eq("idle_ack_req", 32'(mem_bus.mem_req), 32'd0);

    // Reset while a load is outstanding.
    Address = 32'h0000_0030;
    MemRead = 1'b1;
    step();
    check_eq("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
    #2;
    RESET   = 1'b0;
    MemRead = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("mid_rst_read_data", Read_data, 32'd0);
    check_eq("mid_rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_eq("mid_rst_stall_cycles", Stall_cycles, 32'd0);
    rd_model    = '0;
    stall_model = '0;
    step();
    RESET = 1'b1;
    step();
    do_access(32'h0000_0040, 32'h0, 1'b1, 1'b0, 1, 32'h0F0F_0F0F);

`ifdef DMEM_TIMEOUT_EN
    check_eq("bus_err_clear", 32'(Bus_err), 32'd0);
    Address = 32'h0000_0050;
    MemRead = 1'b1;
    step();
    for (int k = 0; k < TO; k++) step();
    stall_model = stall_model + 32'(TO + 1);
    rd_model    = DEADBEEF;
    check_eq("to_done_stall", 32'(Stall), 32'd0);
    check_eq("to_read_data", Read_data, rd_model);
    check_eq("to_bus_err", 32'(Bus_err), 32'd1);
    MemRead = 1'b0;
    step();
    do_access(32'h0000_0060, 32'h0, 1'b1, 1'b0, 0, 32'h2468_ACE0);
    check_eq("to_bus_err_sticky", 32'(Bus_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
